// File: rtl/sobel_edge_3x3_if.sv
// ============================================================================
// Module      : sobel_edge_3x3_if
// Description : Window-in / edge-out bundle for the Sobel edge stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sobel_edge_3x3_if #(
    parameter int CNT_W = 20
);
    logic             matrix_vs;
    logic             matrix_hs;
    logic             matrix_de;
    logic [7:0]       matrix_p11, matrix_p12, matrix_p13;
    logic [7:0]       matrix_p21, matrix_p22, matrix_p23;
    logic [7:0]       matrix_p31, matrix_p32, matrix_p33;
    logic [7:0]       threshold;
    logic             sobel_vs;
    logic             sobel_hs;
    logic             sobel_de;
    logic [7:0]       sobel_mag;
    logic             sobel_bin;
    logic [CNT_W-1:0] edge_count;
    logic             frame_done;

    modport master (
        output matrix_vs, matrix_hs, matrix_de,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        output threshold,
        input  sobel_vs, sobel_hs, sobel_de, sobel_mag, sobel_bin,
        input  edge_count, frame_done
    );

    modport slave (
        input  matrix_vs, matrix_hs, matrix_de,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        input  threshold,
        output sobel_vs, sobel_hs, sobel_de, sobel_mag, sobel_bin,
        output edge_count, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/sobel_edge_3x3.sv
// ============================================================================
// Module      : sobel_edge_3x3
// Description : 3-stage Sobel |Gx|+|Gy| with threshold and per-frame edge count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sobel_edge_3x3 #(
    parameter int CNT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    sobel_edge_3x3_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [9:0]       w_gx_p, w_gx_n, w_gy_p, w_gy_n;
    logic [9:0]       r_gx_p, r_gx_n, r_gy_p, r_gy_n;
    logic [9:0]       r_ax, r_ay;
    logic             r_vs1, r_hs1, r_de1;
    logic             r_vs2, r_hs2, r_de2;
    logic [10:0]      w_sum;
    logic [7:0]       w_mag;
    logic             w_bin;
    logic [7:0]       r_thr;
    logic             r_mvs_d;
    logic             r_svs_d;
    logic [CNT_W-1:0] r_run;
    logic             w_hit;
    logic             w_vs_rise;
    logic             w_unused_p22;

    // The centre pixel carries zero weight in both Sobel kernels.
    assign w_unused_p22 = ^bus.matrix_p22;

    assign w_gx_p = 10'(bus.matrix_p13) + {1'b0, bus.matrix_p23, 1'b0} + 10'(bus.matrix_p33);
    assign w_gx_n = 10'(bus.matrix_p11) + {1'b0, bus.matrix_p21, 1'b0} + 10'(bus.matrix_p31);
    assign w_gy_p = 10'(bus.matrix_p31) + {1'b0, bus.matrix_p32, 1'b0} + 10'(bus.matrix_p33);
    assign w_gy_n = 10'(bus.matrix_p11) + {1'b0, bus.matrix_p12, 1'b0} + 10'(bus.matrix_p13);

    assign w_sum = {1'b0, r_ax} + {1'b0, r_ay};
    assign w_mag = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
    assign w_bin = (w_sum > {3'b000, r_thr});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx_p <= '0; r_gx_n <= '0; r_gy_p <= '0; r_gy_n <= '0;
            r_ax   <= '0; r_ay   <= '0;
            r_vs1  <= 1'b0; r_hs1 <= 1'b0; r_de1 <= 1'b0;
            r_vs2  <= 1'b0; r_hs2 <= 1'b0; r_de2 <= 1'b0;
            bus.sobel_vs  <= 1'b0;
            bus.sobel_hs  <= 1'b0;
            bus.sobel_de  <= 1'b0;
            bus.sobel_mag <= 8'd0;
            bus.sobel_bin <= 1'b0;
        end else begin
            r_gx_p <= w_gx_p; r_gx_n <= w_gx_n;
            r_gy_p <= w_gy_p; r_gy_n <= w_gy_n;
            r_vs1  <= bus.matrix_vs; r_hs1 <= bus.matrix_hs; r_de1 <= bus.matrix_de;
            // Larger minus smaller keeps the magnitude unsigned without wrap.
            r_ax   <= (r_gx_p >= r_gx_n) ? (r_gx_p - r_gx_n) : (r_gx_n - r_gx_p);
            r_ay   <= (r_gy_p >= r_gy_n) ? (r_gy_p - r_gy_n) : (r_gy_n - r_gy_p);
            r_vs2  <= r_vs1; r_hs2 <= r_hs1; r_de2 <= r_de1;
            bus.sobel_vs  <= r_vs2;
            bus.sobel_hs  <= r_hs2;
            bus.sobel_de  <= r_de2;
            bus.sobel_mag <= r_de2 ? w_mag : 8'd0;
            bus.sobel_bin <= r_de2 & w_bin;
        end
    end

    // Threshold is frozen per frame so a mid-frame change lands on the next one.
    always_ff @(posedge clk) begin
        r_mvs_d <= rst ? 1'b0 : bus.matrix_vs;
        if (rst || (bus.matrix_vs && !r_mvs_d)) begin
            r_thr <= bus.threshold;
        end
    end

    assign w_hit     = bus.sobel_de & bus.sobel_bin;
    assign w_vs_rise = bus.sobel_vs & ~r_svs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_svs_d        <= 1'b0;
            r_run          <= '0;
            bus.edge_count <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            r_svs_d        <= bus.sobel_vs;
            bus.frame_done <= w_vs_rise;
            if (w_vs_rise) begin
                bus.edge_count <= r_run;
                // A hit on the publish cycle already belongs to the new frame.
                r_run          <= w_hit ? c_cnt_one : '0;
            end else if (w_hit && (r_run != c_cnt_max)) begin
                r_run <= r_run + c_cnt_one;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_sobel_edge_3x3.sv
// ============================================================================
// Module      : tb_sobel_edge_3x3
// Description : Directed vector table plus frame/reset/sync sequences.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sobel_edge_3x3;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sobel_edge_3x3_if #(.CNT_W(20)) bus  ();
    sobel_edge_3x3_if #(.CNT_W(4))  bus4 ();

    sobel_edge_3x3 #(.CNT_W(20)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    sobel_edge_3x3 #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign {bus4.matrix_vs, bus4.matrix_hs, bus4.matrix_de, bus4.threshold,
            bus4.matrix_p11, bus4.matrix_p12, bus4.matrix_p13,
            bus4.matrix_p21, bus4.matrix_p22, bus4.matrix_p23,
            bus4.matrix_p31, bus4.matrix_p32, bus4.matrix_p33} =
           {bus.matrix_vs, bus.matrix_hs, bus.matrix_de, bus.threshold,
            bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
            bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
            bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [71:0] pix;
        logic [7:0]  thr;
        logic [7:0]  mag;
        logic        bin;
    } vec_t;

    vec_t vecs[10];

    localparam logic [71:0] c_vert = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
    localparam logic [71:0] c_flat = {9{8'd100}};
    localparam logic [71:0] c_t40  = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pix(input logic [71:0] px);
        {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
         bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
         bus.matrix_p31, bus.matrix_p32, bus.matrix_p33} = px;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " vs"},    32'(bus.sobel_vs), 0);
        chk({tag, " hs"},    32'(bus.sobel_hs), 0);
        chk({tag, " de"},    32'(bus.sobel_de), 0);
        chk({tag, " mag"},   32'(bus.sobel_mag), 0);
        chk({tag, " bin"},   32'(bus.sobel_bin), 0);
        chk({tag, " count"}, 32'(bus.edge_count), 0);
        chk({tag, " done"},  32'(bus.frame_done), 0);
    endtask

    // Pulse matrix_vs for one cycle and wait for the resulting frame_done.
    task automatic vs_pulse(input string tag);
        bit seen = 1'b0;
        bus.matrix_de = 1'b0;
        bus.matrix_vs = 1'b1;
        step();
        bus.matrix_vs = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (bus.frame_done) seen = 1'b1;
        end
        chk({tag, " frame_done seen"}, 32'(seen), 1);
    endtask

    task automatic apply_pix(input string tag, input logic [71:0] px,
                             input logic [7:0] mag, input logic bin);
        set_pix(px);
        bus.matrix_de = 1'b1;
        bus.matrix_hs = 1'b1;
        step();
        bus.matrix_de = 1'b0;
        bus.matrix_hs = 1'b0;
        set_pix('0);
        step();
        step();
        chk({tag, " mag"}, 32'(bus.sobel_mag), 32'(mag));
        chk({tag, " bin"}, 32'(bus.sobel_bin), 32'(bin));
        chk({tag, " de"},  32'(bus.sobel_de), 1);
        chk({tag, " hs"},  32'(bus.sobel_hs), 1);
        step();
        chk({tag, " mag idle"}, 32'(bus.sobel_mag), 0);
        chk({tag, " de idle"},  32'(bus.sobel_de), 0);
    endtask

    task automatic stream_frame(input int n, input int n_edges);
        bus.matrix_hs = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_pix(((i % 3 == 0) && (i / 3 < n_edges)) ? c_vert : c_flat);
            bus.matrix_de = 1'b1;
            step();
        end
        bus.matrix_de = 1'b0;
        bus.matrix_hs = 1'b0;
        set_pix('0);
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic close_frame(input string tag, input int exp20, input int exp4);
        vs_pulse(tag);
        chk({tag, " edge_count"},  32'(bus.edge_count), 32'(exp20));
        chk({tag, " edge_count4"}, 32'(bus4.edge_count), 32'(exp4));
        step();
        chk({tag, " done one-shot"}, 32'(bus.frame_done), 0);
    endtask

    logic hv[128], hh[128], hd[128];

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{"flat",      c_flat, 8'd0,   8'd0,   1'b0};
        vecs[1] = '{"vertical",  c_vert, 8'd255, 8'd255, 1'b1};
        vecs[2] = '{"t40",       c_t40,  8'd40,  8'd40,  1'b0};
        vecs[3] = '{"t39",       c_t40,  8'd39,  8'd40,  1'b1};
        vecs[4] = '{"horiz",     {8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd50, 8'd255, 8'd255, 8'd255},
                                 8'd200, 8'd255, 1'b1};
        vecs[5] = '{"left",      {8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0},
                                 8'd100, 8'd80,  1'b0};
        vecs[6] = '{"diag400",   {8'd200, 64'd0},                    8'd254, 8'd255, 1'b1};
        vecs[7] = '{"p33_120",   {64'd0, 8'd60},                     8'd119, 8'd120, 1'b1};
        vecs[8] = '{"sum256",    {40'd0, 8'd128, 24'd0},             8'd255, 8'd255, 1'b1};
        vecs[9] = '{"sum254",    {40'd0, 8'd127, 24'd0},             8'd254, 8'd254, 1'b0};

        rst = 1'b1;
        bus.matrix_vs = 1'b0;
        bus.matrix_hs = 1'b0;
        bus.matrix_de = 1'b0;
        bus.threshold = 8'd0;
        set_pix('0);
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            bus.threshold = vecs[i].thr;
            vs_pulse(vecs[i].name);
            apply_pix(vecs[i].name, vecs[i].pix, vecs[i].mag, vecs[i].bin);
        end

        // Mid-frame threshold change must wait for the next vs rise.
        bus.threshold = 8'd40;
        vs_pulse("thr mid");
        bus.threshold = 8'd39;
        apply_pix("thr held", c_t40, 8'd40, 1'b0);
        vs_pulse("thr next");
        apply_pix("thr new", c_t40, 8'd40, 1'b1);

        bus.threshold = 8'd50;
        vs_pulse("frame A start");
        stream_frame(64, 5);
        close_frame("frame A", 5, 5);
        stream_frame(64, 20);
        close_frame("frame B", 20, 15);

        // Reset in the middle of a stream of edge pixels.
        set_pix(c_vert);
        bus.matrix_de = 1'b1;
        bus.matrix_hs = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pre-reset mag", 32'(bus.sobel_mag), 255);
        rst = 1'b1;
        step();
        chk_all_zero("mid reset");
        step();
        rst = 1'b0;
        step();
        step();
        chk("resume de early", 32'(bus.sobel_de), 0);
        step();
        chk("resume de", 32'(bus.sobel_de), 1);
        chk("resume mag", 32'(bus.sobel_mag), 255);
        bus.matrix_de = 1'b0;
        bus.matrix_hs = 1'b0;
        set_pix('0);
        for (int i = 0; i < 5; i++) step();
        close_frame("post-reset partial", 3, 3);
        stream_frame(64, 0);
        close_frame("frame C", 0, 0);

        // Random syncs and de gaps: outputs are the inputs three cycles late.
        for (int j = 0; j < 120; j++) begin
            hv[j] = 1'($urandom_range(0, 1));
            hh[j] = 1'($urandom_range(0, 1));
            hd[j] = 1'($urandom_range(0, 1));
            bus.matrix_vs = hv[j];
            bus.matrix_hs = hh[j];
            bus.matrix_de = hd[j];
            bus.threshold = 8'($urandom);
            set_pix({$urandom, $urandom, 8'($urandom)});
            step();
            if (j >= 2) begin
                chk("rand vs", 32'(bus.sobel_vs), 32'(hv[j-2]));
                chk("rand hs", 32'(bus.sobel_hs), 32'(hh[j-2]));
                chk("rand de", 32'(bus.sobel_de), 32'(hd[j-2]));
                if (!bus.sobel_de) begin
                    chk("rand gap mag", 32'(bus.sobel_mag), 0);
                    chk("rand gap bin", 32'(bus.sobel_bin), 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
